// File: rtl/tag_unit.sv
// tag_unit: parametrised tag register bank for the content-addressable
// parallel processor array. Holds one tag bit per cell and applies a
// per-cycle tag operation driven by the cell match lines. Also provides
// a some/none flag, a lowest-index priority encoder and a destructive
// tagged-cell iterator with a valid/ready handshake.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   op           tag operation (0 NOP, 1 SET_ALL, 2 LOAD, 3 CLEAR_MATCH,
//                4 KEEP_MATCH, 5 SELECT_FIRST, 6 ITER_START, 7 reserved)
//   match_lines  per-cell match result, bit i = cell i
//   tags         current tag register contents
//   some         OR of all tag bits
//   first_idx    index of the lowest set tag (0 when none)
//   idx_valid    iterator presenting an index
//   idx_ready    consumer accepts idx_out
//   idx_out      iterator index
//   iter_busy    iterator active
//   iter_done    one-cycle pulse at the end of an iteration
//   op_err       one-cycle pulse: op rejected
//   tag_count    registered population count of tags
//
// Optional feature macro: TAG_COUNT_EN enables tag_count (one cycle behind
// tags). When undefined, tag_count is tied to zero.
module tag_unit #(
    parameter int unsigned NUM_CELLS = 100,
    parameter int unsigned IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [2:0]           op,
    input  logic [NUM_CELLS-1:0] match_lines,
    output logic [NUM_CELLS-1:0] tags,
    output logic                 some,
    output logic [IDX_W-1:0]     first_idx,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic [IDX_W-1:0]     idx_out,
    output logic                 iter_busy,
    output logic                 iter_done,
    output logic                 op_err,
    output logic [IDX_W:0]       tag_count
);

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_SET_ALL      = 3'd1,
        OP_LOAD         = 3'd2,
        OP_CLEAR_MATCH  = 3'd3,
        OP_KEEP_MATCH   = 3'd4,
        OP_SELECT_FIRST = 3'd5,
        OP_ITER_START   = 3'd6,
        OP_RESERVED     = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CELLS-1:0] tags_q, tags_d;
    logic                 iter_done_q, iter_done_d;
    logic                 op_err_q, op_err_d;
    logic [NUM_CELLS-1:0] low_bit;
    logic [IDX_W-1:0]     first_idx_c;
    logic                 found;
    op_e                  op_c;

    assign op_c = op_e'(op);

    // Two's-complement trick isolates the lowest set tag bit.
    assign low_bit = tags_q & (~tags_q + NUM_CELLS'(1));

    always_comb begin
        first_idx_c = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (!found && tags_q[i]) begin
                first_idx_c = IDX_W'(i);
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        tags_d      = tags_q;
        state_d     = state_q;
        iter_done_d = 1'b0;
        op_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                case (op_c)
                    OP_NOP:          ;
                    OP_SET_ALL:      tags_d = '1;
                    OP_LOAD:         tags_d = match_lines;
                    OP_CLEAR_MATCH:  tags_d = tags_q & ~match_lines;
                    OP_KEEP_MATCH:   tags_d = tags_q & match_lines;
                    OP_SELECT_FIRST: tags_d = low_bit;
                    OP_ITER_START: begin
                        if (|tags_q) state_d     = ITER;
                        else         iter_done_d = 1'b1;
                    end
                    default:         op_err_d = 1'b1;
                endcase
            end
            ITER: begin
                if (op_c != OP_NOP) op_err_d = 1'b1;
                // idx_out is always the lowest set bit, so accepting it
                // clears exactly that bit.
                if (idx_ready) begin
                    tags_d = tags_q & ~low_bit;
                    if (tags_d == '0) begin
                        state_d     = IDLE;
                        iter_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            tags_q      <= '0;
            iter_done_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tags_q      <= tags_d;
            iter_done_q <= iter_done_d;
            op_err_q    <= op_err_d;
        end
    end

`ifdef TAG_COUNT_EN
    logic [IDX_W:0] tag_count_q, tag_count_d;

    always_comb begin
        tag_count_d = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            tag_count_d = tag_count_d + (IDX_W + 1)'(tags_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) tag_count_q <= '0;
        else     tag_count_q <= tag_count_d;
    end

    assign tag_count = tag_count_q;
`else
    assign tag_count = '0;
`endif

    assign tags      = tags_q;
    assign some      = |tags_q;
    assign first_idx = first_idx_c;
    assign idx_valid = (state_q == ITER);
    assign idx_out   = (state_q == ITER) ? first_idx_c : '0;
    assign iter_busy = (state_q == ITER);
    assign iter_done = iter_done_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_tag_unit.sv
// Directed bench for tag_unit with NUM_CELLS=8.
module tb_tag_unit;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2:0]    op;
    logic [N-1:0]  match_lines;
    logic [N-1:0]  tags;
    logic          some;
    logic [IW-1:0] first_idx;
    logic          idx_valid;
    logic          idx_ready;
    logic [IW-1:0] idx_out;
    logic          iter_busy;
    logic          iter_done;
    logic          op_err;
    logic [IW:0]   tag_count;

    int n_vec = 0;
    int n_err = 0;

    tag_unit #(.NUM_CELLS(N), .IDX_W(IW)) dut (
        .CLK(CLK), .RST(RST), .op(op), .match_lines(match_lines),
        .tags(tags), .some(some), .first_idx(first_idx),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_out(idx_out),
        .iter_busy(iter_busy), .iter_done(iter_done), .op_err(op_err),
        .tag_count(tag_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; op = 3'd0; match_lines = '0; idx_ready = 1'b0;
        tick(); tick();
        check("rst_tags", 32'(tags), 0);
        check("rst_some", 32'(some), 0);
        check("rst_first", 32'(first_idx), 0);
        check("rst_valid", 32'(idx_valid), 0);
        check("rst_idx", 32'(idx_out), 0);
        check("rst_busy", 32'(iter_busy), 0);
        check("rst_done", 32'(iter_done), 0);
        check("rst_err", 32'(op_err), 0);
        check("rst_cnt", 32'(tag_count), 0);
        RST = 1'b0;

        // SET_ALL
        op = 3'd1; tick(); op = 3'd0;
        check("setall_tags", 32'(tags), 32'hFF);
        check("setall_some", 32'(some), 1);
        check("setall_first", 32'(first_idx), 0);
        tick();
`ifdef TAG_COUNT_EN
        check("setall_cnt", 32'(tag_count), 8);
`else
        check("setall_cnt", 32'(tag_count), 0);
`endif

        // LOAD, SELECT_FIRST, CLEAR_MATCH
        op = 3'd2; match_lines = 8'b0110_1000; tick();
        check("load_tags", 32'(tags), 32'h68);
        check("load_first", 32'(first_idx), 3);
        op = 3'd5; tick();
        check("selfirst_tags", 32'(tags), 32'h08);
        check("selfirst_first", 32'(first_idx), 3);
        op = 3'd3; match_lines = 8'h08; tick(); op = 3'd0;
        check("clr_tags", 32'(tags), 0);
        check("clr_some", 32'(some), 0);
        check("clr_first", 32'(first_idx), 0);

        // KEEP_MATCH and reserved op
        op = 3'd2; match_lines = 8'hF3; tick();
        op = 3'd4; match_lines = 8'hA6; tick();
        check("keep_tags", 32'(tags), 32'hA2);
        check("keep_first", 32'(first_idx), 1);
        op = 3'd7; tick(); op = 3'd0;
        check("rsv_err", 32'(op_err), 1);
        check("rsv_tags", 32'(tags), 32'hA2);
        tick();
        check("rsv_err_end", 32'(op_err), 0);

        // Back-to-back iteration over 1,5,7
        op = 3'd6; idx_ready = 1'b1; tick(); op = 3'd0;
        check("it_valid0", 32'(idx_valid), 1);
        check("it_busy0", 32'(iter_busy), 1);
        check("it_idx0", 32'(idx_out), 1);
        tick();
        check("it_idx1", 32'(idx_out), 5);
        tick();
        check("it_idx2", 32'(idx_out), 7);
        check("it_done_early", 32'(iter_done), 0);
        tick();
        check("it_done", 32'(iter_done), 1);
        check("it_valid_end", 32'(idx_valid), 0);
        check("it_busy_end", 32'(iter_busy), 0);
        check("it_tags_end", 32'(tags), 0);
        idx_ready = 1'b0; tick();
        check("it_done_pulse", 32'(iter_done), 0);

        // Stalled iteration, op during ITER
        op = 3'd2; match_lines = 8'b1010_0010; tick();
        op = 3'd6; tick(); op = 3'd0;
        check("st_idx0", 32'(idx_out), 1);
        tick();
        check("st_idx0_hold", 32'(idx_out), 1);
        check("st_tags_hold", 32'(tags), 32'hA2);
        idx_ready = 1'b1; op = 3'd1; tick();
        check("st_operr", 32'(op_err), 1);
        check("st_idx1", 32'(idx_out), 5);
        check("st_tags1", 32'(tags), 32'hA0);
        idx_ready = 1'b0; op = 3'd0; tick();
        check("st_operr_end", 32'(op_err), 0);
        check("st_idx1_hold", 32'(idx_out), 5);
        check("st_tags1_hold", 32'(tags), 32'hA0);
        idx_ready = 1'b1; tick();
        check("st_idx2", 32'(idx_out), 7);
        idx_ready = 1'b0; tick();
        check("st_idx2_hold", 32'(idx_out), 7);
        idx_ready = 1'b1; tick(); idx_ready = 1'b0;
        check("st_done", 32'(iter_done), 1);
        check("st_tags_end", 32'(tags), 0);

        // ITER_START with no tags
        op = 3'd6; tick(); op = 3'd0;
        check("empty_done", 32'(iter_done), 1);
        check("empty_valid", 32'(idx_valid), 0);
        check("empty_busy", 32'(iter_busy), 0);
        tick();
        check("empty_done_end", 32'(iter_done), 0);

        // Reset mid-iteration
        op = 3'd2; match_lines = 8'b1010_0010; tick();
        op = 3'd6; idx_ready = 1'b1; tick(); op = 3'd0;
        check("ri_idx0", 32'(idx_out), 1);
        tick();
        check("ri_idx1", 32'(idx_out), 5);
        RST = 1'b1; tick(); RST = 1'b0; idx_ready = 1'b0;
        check("ri_tags", 32'(tags), 0);
        check("ri_valid", 32'(idx_valid), 0);
        check("ri_busy", 32'(iter_busy), 0);
        check("ri_done", 32'(iter_done), 0);
        tick();
        check("ri_done_after", 32'(iter_done), 0);
        check("ri_valid_after", 32'(idx_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tag_unit.md
# tag_unit

Parametrised tag register bank for the content-addressable parallel processor array; successor to the fixed single-mode tag block. Holds one tag bit per cell and applies a per-cycle tag operation driven by the array's match lines. Adds load/keep/clear modes, a some/none flag, a lowest-index priority encoder and a destructive tagged-cell iterator with valid/ready handshake. Sits between the cell match-line outputs and the controller that sequences word-parallel writes.

## Interface
- NUM_CELLS, 100, number of cells/tag bits (≥2)
- IDX_W, $clog2(NUM_CELLS), width of cell index outputs
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- op  in  3  tag operation for this cycle (encoding below)
- match_lines  in  NUM_CELLS  per-cell match result, bit i = cell i
- tags  out  NUM_CELLS  current tag register contents
- some  out  1  OR of all tag bits
- first_idx  out  IDX_W  index of lowest set tag; 0 when some=0
- idx_valid  out  1  iterator presenting an index
- idx_ready  in  1  consumer accepts idx_out
- idx_out  out  IDX_W  iterator index
- iter_busy  out  1  iterator in ITER state
- iter_done  out  1  one-cycle pulse at end of iteration
- op_err  out  1  one-cycle pulse: op rejected
- tag_count  out  IDX_W+1  population count of tags (see Configuration)

## Operation
- op encoding: 0 NOP; 1 SET_ALL (tags←all 1); 2 LOAD (tags←match_lines); 3 CLEAR_MATCH (tags←tags & ~match_lines); 4 KEEP_MATCH (tags←tags & match_lines); 5 SELECT_FIRST (keep only lowest-index set bit; no-op if none); 6 ITER_START; 7 reserved.
- op 7: no state change, op_err pulses next cycle.
- Priority: lowest index wins (cell 0 highest).
- some, first_idx: combinational from tag register; no extra latency vs tags.
- FSM states IDLE, ITER.
  - IDLE, op=6, some=1 → ITER. op=6, some=0 → stay IDLE, iter_done pulses next cycle.
  - ITER: idx_valid=1, idx_out=first_idx. On idx_valid&&idx_ready, tag bit idx_out cleared at that edge.
  - ITER, after clearing the last set bit → IDLE, idx_valid=0, iter_done=1 for exactly one cycle.
  - In ITER any op≠0 ignored and op_err pulses next cycle; tags change only through iterator handshake.
- idx_out stable while idx_valid=1 and idx_ready=0.

## Timing
- Reset values: tags=0, state IDLE, some=0, first_idx=0, idx_valid=0, idx_out=0, iter_busy=0, iter_done=0, op_err=0, tag_count=0.
- op at edge N → tags/some/first_idx updated after edge N (visible cycle N+1).
- ITER_START at edge N → idx_valid=1 in cycle N+1 (if some).
- Back-to-back acceptance: idx_ready held high gives one index per cycle; k tagged cells → k handshake cycles, iter_done in cycle after the last.
- iter_busy=1 from ITER entry through last handshake cycle; 0 in the iter_done cycle.
- RST asserted mid-iteration: immediate return to reset values at that edge; no iter_done.
- RST dominates op and handshake in the same cycle.

## Configuration
- TAG_COUNT_EN defined: tag_count = popcount of tags, registered, one cycle behind tags (valid cycle N+2 for op at edge N).
- Not defined: counter logic removed, tag_count tied to 0; all other behaviour identical.

## Test plan
- NUM_CELLS=8: reset, then SET_ALL → tags=8'hFF, some=1, first_idx=0; tag_count=8 one cycle later (with TAG_COUNT_EN).
- LOAD match=8'b0110_1000 then SELECT_FIRST → tags=8'b0000_1000, first_idx=3; CLEAR_MATCH match=8'h08 → tags=0, some=0, first_idx=0.
- LOAD 8'b1010_0010, ITER_START, idx_ready=1 → idx_out 1,5,7 on consecutive cycles, iter_done one cycle later, tags=0.
- Same tags, idx_ready toggled 0/1 → idx_out held stable while stalled, same sequence 1,5,7; op=1 during ITER → op_err pulse, tags unaffected.
- ITER_START with tags=0 → no idx_valid, iter_done pulse next cycle; op=7 → op_err pulse, tags unchanged.
- RST after first handshake of 3-index iteration → tags=0, idx_valid=0, iter_busy=0, no iter_done.
